// File: rtl/noc_pkg.sv
// Shared types and helpers for the XY mesh router: port enum, header field
// extraction and the dimension-ordered route function.
package noc_pkg;
  localparam int NUM_PORTS   = 5;
  localparam int MAX_COORD_W = 16;
  localparam int MAX_DATA_W  = 256;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  // Callers zero-extend the flit to MAX_DATA_W; data_w/coord_w locate the fields.
  function automatic logic [MAX_COORD_W-1:0] hdr_dest_x(input logic [MAX_DATA_W-1:0] d,
                                                         input int data_w, input int coord_w);
    logic [MAX_DATA_W-1:0] mask;
    mask = (MAX_DATA_W'(1) << coord_w) - MAX_DATA_W'(1);
    return MAX_COORD_W'((d >> (data_w - coord_w)) & mask);
  endfunction

  function automatic logic [MAX_COORD_W-1:0] hdr_dest_y(input logic [MAX_DATA_W-1:0] d,
                                                         input int data_w, input int coord_w);
    logic [MAX_DATA_W-1:0] mask;
    mask = (MAX_DATA_W'(1) << coord_w) - MAX_DATA_W'(1);
    return MAX_COORD_W'((d >> (data_w - 2*coord_w)) & mask);
  endfunction

  function automatic port_e xy_route(input logic [MAX_COORD_W-1:0] dx, input logic [MAX_COORD_W-1:0] dy,
                                     input logic [MAX_COORD_W-1:0] cx, input logic [MAX_COORD_W-1:0] cy);
    if (dx > cx)      return PORT_E;
    else if (dx < cx) return PORT_W;
    else if (dy > cy) return PORT_S;
    else if (dy < cy) return PORT_N;
    else              return PORT_L;
  endfunction
endpackage

// File: rtl/noc_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// refused even when a pop happens on the same edge.
module noc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr, r_rd;
  logic             w_do_push, w_do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/xy_mesh_router.sv
// Five-port XY mesh router: per-input FIFOs, per-output round-robin arbiter
// and registered outputs; flits routed to absent ports are dropped and counted.
module xy_mesh_router
  import noc_pkg::*;
#(
  parameter int                   XCOORD     = 1,
  parameter int                   YCOORD     = 1,
  parameter int                   COORD_W    = 4,
  parameter int                   DATA_W     = 32,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [NUM_PORTS-1:0] PORT_EN    = 5'b11111
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
  output logic [NUM_PORTS-1:0]              in_ready,
  output logic [NUM_PORTS-1:0]              out_valid,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  out_data,
  input  logic [NUM_PORTS-1:0]              out_ready,
  output logic [15:0]                       drop_count
);
  logic [NUM_PORTS-1:0]                 w_full, w_empty, w_pop, w_drop;
  logic [NUM_PORTS-1:0][DATA_W-1:0]     w_head;
  port_e                                w_route [NUM_PORTS];
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  w_req, w_gnt;  // [output][input]
  logic [15:0]                          r_drop;
  logic [2:0]                           w_ndrop;
  logic [16:0]                          w_dsum;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    if (PORT_EN[p]) begin : g_fifo
      noc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid[p] && in_ready[p]),
        .i_data  (in_data[p]),
        .i_pop   (w_pop[p]),
        .o_full  (w_full[p]),
        .o_empty (w_empty[p]),
        .o_head  (w_head[p])
      );
    end else begin : g_off
      assign w_full[p]  = 1'b1;
      assign w_empty[p] = 1'b1;
      assign w_head[p]  = '0;
    end
    assign in_ready[p] = PORT_EN[p] && !w_full[p];
    assign w_route[p]  = xy_route(hdr_dest_x(MAX_DATA_W'(w_head[p]), DATA_W, COORD_W),
                                  hdr_dest_y(MAX_DATA_W'(w_head[p]), DATA_W, COORD_W),
                                  MAX_COORD_W'(XCOORD), MAX_COORD_W'(YCOORD));
    assign w_drop[p]   = !w_empty[p] && !PORT_EN[w_route[p]];
  end

  always_comb begin
    w_req = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        w_req[o][i] = PORT_EN[o] && !w_empty[i] && (int'(w_route[i]) == o);
  end

  // Each input requests at most one output, so OR-ing grants never double-pops.
  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int i = 0; i < NUM_PORTS; i++)
        w_pop[i] = w_pop[i] | w_gnt[o][i];
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    if (PORT_EN[o]) begin : g_on
      logic [2:0]           r_last;
      logic                 r_vld;
      logic [DATA_W-1:0]    r_dat, w_sel;
      logic [NUM_PORTS-1:0] w_g;
      logic [2:0]           w_gidx;
      logic                 w_load;

      assign w_load = !r_vld || out_ready[o];

      // Scan starts one past the last winner and wraps.
      always_comb begin
        int  idx;
        logic found;
        w_g    = '0;
        w_gidx = r_last;
        found  = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = (int'(r_last) + k) % NUM_PORTS;
          if (w_load && !found && w_req[o][idx]) begin
            w_g[idx] = 1'b1;
            w_gidx   = 3'(idx);
            found    = 1'b1;
          end
        end
      end

      always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++)
          if (w_g[i]) w_sel = w_head[i];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld  <= 1'b0;
          r_dat  <= '0;
          r_last <= 3'd4;
        end else if (|w_g) begin
          r_vld  <= 1'b1;
          r_dat  <= w_sel;
          r_last <= w_gidx;
        end else if (out_ready[o]) begin
          r_vld  <= 1'b0;
        end
      end

      assign w_gnt[o]     = w_g;
      assign out_valid[o] = r_vld;
      assign out_data[o]  = r_dat;
    end else begin : g_off
      assign w_gnt[o]     = '0;
      assign out_valid[o] = 1'b0;
      assign out_data[o]  = '0;
    end
  end

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      w_ndrop = w_ndrop + 3'(w_drop[i]);
    w_dsum = {1'b0, r_drop} + 17'(w_ndrop);
  end

  always_ff @(posedge clk) begin
    if (reset) r_drop <= '0;
    else       r_drop <= w_dsum[16] ? 16'hFFFF : w_dsum[15:0];
  end

  assign drop_count = r_drop;
endmodule

// File: tb/tb_xy_mesh_router.sv
// Bench for xy_mesh_router: a fully populated and a sparse router run side by
// side against a queue-based reference model, with directed and random traffic.
module tb_xy_mesh_router;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [4:0] EN_A = 5'b11111;
  localparam logic [4:0] EN_B = 5'b10110;

  logic clk = 1'b0;
  logic reset;
  logic [4:0]         iv   [2];
  logic [4:0][DW-1:0] id   [2];
  logic [4:0]         ordy [2];
  logic [4:0]         ir   [2];
  logic [4:0]         ov   [2];
  logic [4:0][DW-1:0] od   [2];
  logic [15:0]        dc   [2];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq [2][5][$];
  logic [4:0]    m_ov [2];
  logic [DW-1:0] m_od [2][5];
  int            m_last [2][5];
  int            m_drop [2];

  always #5 clk = ~clk;

  xy_mesh_router #(.XCOORD(1), .YCOORD(1), .COORD_W(4), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
                   .PORT_EN(EN_A)) dut_a (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_data(id[0]), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]), .drop_count(dc[0]));

  xy_mesh_router #(.XCOORD(1), .YCOORD(1), .COORD_W(4), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
                   .PORT_EN(EN_B)) dut_b (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_data(id[1]), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]), .drop_count(dc[1]));

  function automatic logic [4:0] en(input int d);
    return (d == 0) ? EN_A : EN_B;
  endfunction

  function automatic logic [DW-1:0] mk(input int x, input int y, input int pl);
    return {4'(x), 4'(y), 24'(pl)};
  endfunction

  // Router sits at (1,1): E/W settle X first, then S/N, else local.
  function automatic int route(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[31:28]);
    dy = int'(f[27:24]);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 1) return 1;
    if (dy < 1) return 0;
    return 4;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic [4:0] rdy, popd;
      logic [4:0] e;
      int w, i;
      e = en(d);
      if (reset) begin
        for (int p = 0; p < 5; p++) begin
          mq[d][p].delete();
          m_od[d][p] = '0;
          m_last[d][p] = 4;
        end
        m_ov[d] = '0;
        m_drop[d] = 0;
      end else begin
        popd = '0;
        for (int p = 0; p < 5; p++) rdy[p] = e[p] && (mq[d][p].size() < DEPTH);
        for (int o = 0; o < 5; o++) begin
          if (e[o] && (!m_ov[d][o] || ordy[d][o])) begin
            w = -1;
            for (int k = 1; k <= 5; k++) begin
              i = (m_last[d][o] + k) % 5;
              if (w < 0 && mq[d][i].size() > 0 && route(mq[d][i][0]) == o) w = i;
            end
            if (w >= 0) begin
              m_od[d][o] = mq[d][w][0];
              m_ov[d][o] = 1'b1;
              m_last[d][o] = w;
              popd[w] = 1'b1;
            end else if (ordy[d][o]) begin
              m_ov[d][o] = 1'b0;
            end
          end
        end
        for (int p = 0; p < 5; p++)
          if (mq[d][p].size() > 0 && !e[route(mq[d][p][0])]) begin
            popd[p] = 1'b1;
            if (m_drop[d] < 65535) m_drop[d]++;
          end
        for (int p = 0; p < 5; p++) begin
          if (popd[p]) void'(mq[d][p].pop_front());
          if (iv[d][p] && rdy[p]) mq[d][p].push_back(id[d][p]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [4:0] er;
      logic [4:0] e;
      e = en(d);
      for (int p = 0; p < 5; p++) er[p] = e[p] && (mq[d][p].size() < DEPTH);
      chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(er));
      chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(m_ov[d]));
      for (int o = 0; o < 5; o++)
        chk($sformatf("out_data[%0d][%0d]", d, o), 64'(od[d][o]), 64'(m_od[d][o]));
      chk($sformatf("drop_count[%0d]", d), 64'(dc[d]), 64'(m_drop[d]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] dq[$];
    int acc;
    logic hit;
    for (int d = 0; d < 2; d++) begin
      iv[d] = '0; id[d] = '0; ordy[d] = 5'b11111; m_ov[d] = '0; m_drop[d] = 0;
      for (int p = 0; p < 5; p++) begin m_od[d][p] = '0; m_last[d][p] = 4; end
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready_b", 64'(ir[1]), 64'(5'b10110));
    chk("rst_out_valid_b", 64'(ov[1]), 64'(0));
    chk("rst_drop_b", 64'(dc[1]), 64'(0));

    // Single flit L -> E
    iv[0][4] = 1'b1; id[0][4] = mk(2, 1, 'hA5);
    tick();
    iv[0] = '0;
    chk("single_early", 64'(ov[0]), 64'(0));
    tick();
    chk("single_valid", 64'(ov[0]), 64'(5'b00100));
    chk("single_data", 64'(od[0][2]), 64'(mk(2, 1, 'hA5)));
    tick();

    // Contention N,S,W -> L
    iv[0] = 5'b01011;
    id[0][0] = mk(1, 1, 'h10); id[0][1] = mk(1, 1, 'h11); id[0][3] = mk(1, 1, 'h13);
    tick();
    iv[0] = '0;
    tick(); chk("cont_1", 64'(od[0][4]), 64'(mk(1, 1, 'h10)));
    tick(); chk("cont_2", 64'(od[0][4]), 64'(mk(1, 1, 'h11)));
    tick(); chk("cont_3", 64'(od[0][4]), 64'(mk(1, 1, 'h13)));
    tick(); chk("cont_idle", 64'(ov[0]), 64'(0));
    // Pointer rests on W, so N now outranks S
    iv[0] = 5'b00011; id[0][0] = mk(1, 1, 'h20); id[0][1] = mk(1, 1, 'h21);
    tick();
    iv[0] = '0;
    tick(); chk("rep_1", 64'(od[0][4]), 64'(mk(1, 1, 'h20)));
    tick(); chk("rep_2", 64'(od[0][4]), 64'(mk(1, 1, 'h21)));
    tick();

    // Backpressure on E
    ordy[0] = 5'b11011;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      iv[0][3] = (acc < DEPTH + 2);
      id[0][3] = mk(2, 1, 'h100 + acc);
      hit = ir[0][3] && iv[0][3];
      tick();
      if (hit) acc++;
    end
    iv[0] = '0;
    chk("bp_accepts", 64'(acc), 64'(DEPTH + 1));
    chk("bp_in_ready", 64'(ir[0][3]), 64'(0));
    chk("bp_hold", 64'(od[0][2]), 64'(mk(2, 1, 'h100)));
    ordy[0] = 5'b11111;
    for (int c = 0; c < 8; c++) begin
      if (ov[0][2]) dq.push_back(od[0][2]);
      tick();
    end
    chk("bp_count", 64'(dq.size()), 64'(DEPTH + 1));
    for (int k = 0; k < dq.size(); k++)
      chk($sformatf("bp_order%0d", k), 64'(dq[k]), 64'(mk(2, 1, 'h100 + k)));

    // Sparse router: L flit towards absent W is dropped, S flit goes to S
    iv[1] = 5'b10010; id[1][4] = mk(0, 1, 'h33); id[1][1] = mk(1, 2, 'h44);
    tick();
    iv[1] = '0;
    tick();
    chk("dis_drop", 64'(dc[1]), 64'(1));
    chk("dis_valid", 64'(ov[1]), 64'(5'b00010));
    chk("dis_data", 64'(od[1][1]), 64'(mk(1, 2, 'h44)));
    tick();

    // Random traffic on both routers
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d] = 5'($urandom);
        ordy[d] = 5'($urandom) | 5'($urandom);
        for (int p = 0; p < 5; p++)
          id[d][p] = mk($urandom_range(0, 2), $urandom_range(0, 2), int'($urandom));
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin iv[d] = '0; ordy[d] = 5'b11111; end
    for (int c = 0; c < 10; c++) tick();

    // Mid-traffic reset: one flit registered on L, three buffered
    ordy[0] = '0;
    iv[0] = 5'b01011;
    id[0][0] = mk(1, 1, 'h50); id[0][1] = mk(1, 1, 'h51); id[0][3] = mk(1, 1, 'h53);
    tick();
    iv[0] = 5'b00100; id[0][2] = mk(1, 1, 'h52);
    tick();
    iv[0] = '0;
    chk("mid_pre_valid", 64'(ov[0]), 64'(5'b10000));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", 64'(ov[0]), 64'(0));
    chk("mid_ready", 64'(ir[0]), 64'(5'b11111));
    ordy[0] = 5'b11111;
    tick(); tick(); tick();
    chk("mid_no_stale", 64'(ov[0]), 64'(0));
    iv[0][4] = 1'b1; id[0][4] = mk(1, 0, 'h77);
    tick();
    iv[0] = '0;
    tick();
    chk("post_valid", 64'(ov[0]), 64'(5'b00001));
    chk("post_data", 64'(od[0][0]), 64'(mk(1, 0, 'h77)));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
